// File: rtl/irq_sequencer.sv
// Multi-source interrupt sequencer. Latches rising edges on the irq lines,
// grants the lowest-indexed eligible source, then injects bubbles, two
// interrupt-entry words carrying the return PC, and a one-cycle redirect to
// that source's vector.
module irq_sequencer #(
  parameter int unsigned             NUM_IRQ      = 4,
  parameter int unsigned             PC_WIDTH     = 32,
  parameter int unsigned             INSTR_WIDTH  = 16,
  parameter logic [2:0]              IMM_FN       = 3'b100,
  parameter logic [INSTR_WIDTH-1:0]  BUBBLE_INSTR = 16'h07F8,
  parameter logic [INSTR_WIDTH-1:0]  INT_INSTR_0  = 16'hF480,
  parameter logic [INSTR_WIDTH-1:0]  INT_INSTR_1  = 16'h0000,
  parameter logic [PC_WIDTH-1:0]     IVT_BASE     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_IRQ-1:0]     irq,
  input  logic [NUM_IRQ-1:0]     irq_mask,
  input  logic                   ie,
  input  logic [2:0]             function_bits,
  input  logic                   iam_jmp,
  input  logic [PC_WIDTH-1:0]    next_pc,
  output logic                   busy,
  output logic                   inject_valid,
  output logic [INSTR_WIDTH-1:0] inject_instr,
  output logic                   bubble,
  output logic                   save_pc_valid,
  output logic [PC_WIDTH-1:0]    save_pc,
  output logic                   redirect,
  output logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [NUM_IRQ-1:0]     irq_ack
);

  localparam int unsigned ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StImm,
    StBub,
    StJwait,
    StPush0,
    StPush1,
    StRedir
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d;
  logic [NUM_IRQ-1:0]  irq_dly_q;
  logic [PC_WIDTH-1:0] save_pc_q, save_pc_d;
  logic [ID_W-1:0]     id_q, id_d;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  elig;
  logic                grant_any;
  logic [ID_W-1:0]     grant_id;

  // Edge detect and lowest-index priority pick over eligible pending sources.
  always_comb begin
    rise      = irq & ~irq_dly_q;
    elig      = ie ? (pend_q & ~irq_mask) : '0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      if (elig[k]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(k);
      end
    end
  end

  // Next-state, pending bookkeeping and return-PC tracking.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    save_pc_d = save_pc_q;
    id_d      = id_q;
    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          id_d      = grant_id;
          save_pc_d = next_pc;
          pend_d    = pend_q & ~(NUM_IRQ'(1) << grant_id);
          if (iam_jmp) begin
            state_d = StJwait;
          end else if (function_bits == IMM_FN) begin
            state_d = StImm;
          end else begin
            state_d = StBub;
          end
        end
      end
      StImm: begin
        // Return past the immediate word that follows the current instruction.
        save_pc_d = save_pc_q + PC_WIDTH'(1);
        state_d   = StBub;
      end
      StBub: state_d = StPush0;
      StJwait: begin
        // The jump has resolved by now; return to its target.
        save_pc_d = next_pc;
        state_d   = StPush0;
      end
      StPush0: state_d = StPush1;
      StPush1: state_d = StRedir;
      StRedir: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A new edge on the granted source at the grant edge keeps it pending.
    pend_d = pend_d | rise;
  end

  // State and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pend_q    <= '0;
      irq_dly_q <= '0;
      save_pc_q <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      irq_dly_q <= irq;
      save_pc_q <= save_pc_d;
      id_q      <= id_d;
    end
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    busy          = (state_q != StIdle);
    inject_valid  = 1'b0;
    inject_instr  = '0;
    bubble        = 1'b0;
    save_pc_valid = 1'b0;
    save_pc       = save_pc_q;
    redirect      = 1'b0;
    redirect_pc   = '0;
    irq_ack       = '0;
    unique case (state_q)
      StImm, StBub, StJwait: begin
        inject_valid = 1'b1;
        bubble       = 1'b1;
        inject_instr = BUBBLE_INSTR;
      end
      StPush0: begin
        inject_valid  = 1'b1;
        inject_instr  = INT_INSTR_0;
        save_pc_valid = 1'b1;
      end
      StPush1: begin
        inject_valid = 1'b1;
        inject_instr = INT_INSTR_1;
      end
      StRedir: begin
        redirect    = 1'b1;
        redirect_pc = IVT_BASE + PC_WIDTH'(id_q);
        irq_ack     = NUM_IRQ'(1) << id_q;
      end
      default: begin
        inject_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: a service-script model checked every cycle plus
// directed scenarios with literal expectations.
module tb_irq_sequencer;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [N-1:0] irq, irq_mask;
  logic        ie, iam_jmp;
  logic [2:0]  fn;
  logic [31:0] npc;
  logic        busy, inject_valid, bubble, save_pc_valid, redirect;
  logic [15:0] inject_instr;
  logic [31:0] save_pc, redirect_pc;
  logic [N-1:0] irq_ack;

  int vectors = 0;
  int miscompares = 0;

  irq_sequencer #(
    .NUM_IRQ (N),
    .IVT_BASE(32'h100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .irq          (irq),
    .irq_mask     (irq_mask),
    .ie           (ie),
    .function_bits(fn),
    .iam_jmp      (iam_jmp),
    .next_pc      (npc),
    .busy         (busy),
    .inject_valid (inject_valid),
    .inject_instr (inject_instr),
    .bubble       (bubble),
    .save_pc_valid(save_pc_valid),
    .save_pc      (save_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .irq_ack      (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a service is a script of cycle kinds (0 bubble, 1 entry word 0,
  // 2 entry word 1, 3 redirect) with an action applied when leaving each
  // cycle (0 none, 1 return past immediate, 2 take resolved jump target).
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '0;
  logic [31:0]  m_save = '0;
  int           m_id = 0;
  int           q_kind[$];
  int           q_act[$];

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = '0; m_prev = '0; m_save = '0; m_id = 0;
        q_kind.delete(); q_act.delete();
      end else begin
        r = irq & ~m_prev;
        m_prev = irq;
        e = ie ? (m_pend & ~irq_mask) : '0;
        if (q_kind.size() != 0) begin
          if (q_act[0] == 1) m_save = m_save + 32'd1;
          else if (q_act[0] == 2) m_save = npc;
          void'(q_kind.pop_front());
          void'(q_act.pop_front());
        end else if (e != 0) begin
          for (int k = N - 1; k >= 0; k--) if (e[k]) m_id = k;
          m_pend[m_id] = 1'b0;
          m_save = npc;
          if (iam_jmp) begin
            q_kind.push_back(0); q_act.push_back(2);
          end else if (fn == 3'b100) begin
            q_kind.push_back(0); q_act.push_back(1);
            q_kind.push_back(0); q_act.push_back(0);
          end else begin
            q_kind.push_back(0); q_act.push_back(0);
          end
          for (int s = 1; s <= 3; s++) begin
            q_kind.push_back(s); q_act.push_back(0);
          end
        end
        m_pend = m_pend | r;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    int kd;
    logic [15:0] ei;
    forever begin
      @(negedge clk);
      kd = (q_kind.size() != 0) ? q_kind[0] : -1;
      ei = (kd == 0) ? 16'h07F8 : (kd == 1) ? 16'hF480 : 16'h0000;
      chk("busy", busy, kd >= 0);
      chk("inject_valid", inject_valid, kd >= 0 && kd <= 2);
      chk("inject_instr", inject_instr, ei);
      chk("bubble", bubble, kd == 0);
      chk("save_pc_valid", save_pc_valid, kd == 1);
      chk("save_pc", save_pc, m_save);
      chk("redirect", redirect, kd == 3);
      chk("redirect_pc", redirect_pc, (kd == 3) ? 32'h100 + m_id : 32'h0);
      chk("irq_ack", irq_ack, (kd == 3) ? (N'(1) << m_id) : N'(0));
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy && q_kind.size() == 0) done = 1'b1;
    end
    if (!done) chk("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    irq = '0; irq_mask = '0; ie = 1'b0; iam_jmp = 1'b0; fn = 3'd0; npc = '0;
    rst = 1'b1;
    nclk(3);
    #3 rst = 1'b0;
    nclk(1);
    chk("rst_busy", busy, 0);
    chk("rst_instr", inject_instr, 0);
    chk("rst_save_pc", save_pc, 0);
    chk("rst_redirect_pc", redirect_pc, 0);

    // Plain source 2
    ie = 1'b1; npc = 32'h40; irq = 4'b0100;
    nclk(1); chk("t1_wait", busy, 0);
    nclk(1); chk("t1_bub_instr", inject_instr, 16'h07F8); chk("t1_bub", bubble, 1);
    nclk(1); chk("t1_p0_instr", inject_instr, 16'hF480); chk("t1_p0_pc", save_pc, 32'h40);
    chk("t1_p0_spv", save_pc_valid, 1);
    nclk(1); chk("t1_p1_instr", inject_instr, 16'h0000); chk("t1_p1_iv", inject_valid, 1);
    chk("t1_p1_bub", bubble, 0);
    nclk(1); chk("t1_redir", redirect, 1); chk("t1_rpc", redirect_pc, 32'h102);
    chk("t1_ack", irq_ack, 4'b0100);
    irq = '0;
    nclk(1); chk("t1_idle", busy, 0); chk("t1_redir_off", redirect, 0);

    // Immediate case with PC wrap, source 0
    fn = 3'b100; npc = 32'hFFFF_FFFF; irq = 4'b0001;
    nclk(1); chk("t2_wait", busy, 0);
    nclk(1); chk("t2_bub0", bubble, 1); chk("t2_pc_cap", save_pc, 32'hFFFF_FFFF);
    nclk(1); chk("t2_bub1", bubble, 1);
    nclk(1); chk("t2_p0_pc", save_pc, 32'h0); chk("t2_p0_spv", save_pc_valid, 1);
    nclk(1); chk("t2_p1", inject_instr, 16'h0000);
    nclk(1); chk("t2_redir", redirect, 1); chk("t2_rpc", redirect_pc, 32'h100);
    chk("t2_ack", irq_ack, 4'b0001);
    irq = '0; fn = 3'd0;
    nclk(1);

    // Jump case, source 1
    iam_jmp = 1'b1; npc = 32'h123; irq = 4'b0010;
    nclk(1); chk("t3_wait", busy, 0);
    nclk(1); chk("t3_jwait", bubble, 1);
    npc = 32'h200; iam_jmp = 1'b0;
    nclk(1); chk("t3_p0_pc", save_pc, 32'h200); chk("t3_p0_spv", save_pc_valid, 1);
    nclk(1);
    nclk(1); chk("t3_rpc", redirect_pc, 32'h101); chk("t3_ack", irq_ack, 4'b0010);
    irq = '0;
    nclk(1);

    // Priority and retention of a masked source
    npc = 32'h50; irq_mask = 4'b0010; irq = 4'b1010;
    nclk(1); chk("t4_wait", busy, 0);
    nclk(1); chk("t4_busy", busy, 1);
    nclk(3); chk("t4_rpc3", redirect_pc, 32'h103); chk("t4_ack3", irq_ack, 4'b1000);
    irq = '0;
    nclk(1); chk("t4_held0", busy, 0);
    nclk(1); chk("t4_held1", busy, 0);
    irq_mask = '0;
    nclk(1); chk("t4_unmask_grant", busy, 1);
    nclk(3); chk("t4_rpc1", redirect_pc, 32'h101); chk("t4_ack1", irq_ack, 4'b0010);
    nclk(1);

    // Global enable off: edges latch, no grant
    ie = 1'b0; irq = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      nclk(1); chk("t5_ie_off", busy, 0);
    end
    ie = 1'b1;
    nclk(1); chk("t5_ie_on", busy, 1);
    nclk(3); chk("t5_ack", irq_ack, 4'b0100);
    irq = '0;
    nclk(1);

    // Simultaneous requests back to back
    irq = 4'b0011;
    nclk(5); chk("t6_ack0", irq_ack, 4'b0001);
    nclk(1); chk("t6_gap", busy, 0);
    nclk(1); chk("t6_next", busy, 1);
    irq = '0;
    wait_idle(20);
    nclk(1);

    // Reset during PUSH1 with a masked source also pending
    irq_mask = 4'b0100; irq = 4'b0101;
    nclk(4); chk("t7_p1", inject_valid, 1); chk("t7_p1_instr", inject_instr, 16'h0000);
    #3 rst = 1'b1; irq = '0;
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_iv", inject_valid, 0);
    chk("t7_rst_pc", save_pc, 0);
    chk("t7_rst_spv", save_pc_valid, 0);
    nclk(2);
    #3 rst = 1'b0; irq_mask = '0;
    for (int i = 0; i < 8; i++) begin
      nclk(1); chk("t7_after_busy", busy, 0); chk("t7_after_redir", redirect, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
